// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - stall bit indices, stall masks, FSM encoding and stall merge helper for pipe_ctrl
package pipe_ctrl_pkg;

    // Bit positions inside the shared stall_signal bus
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    // A stall at stage k freezes stage k and every stage upstream of it
    localparam logic [4:0] STALL_MASK_NONE = 5'b00000;
    localparam logic [4:0] STALL_MASK_IF   = (5'b1 << STALL_PC) | (5'b1 << STALL_IF);
    localparam logic [4:0] STALL_MASK_ID   = STALL_MASK_IF | (5'b1 << STALL_ID);
    localparam logic [4:0] STALL_MASK_MEM  = STALL_MASK_ID | (5'b1 << STALL_EX) | (5'b1 << STALL_MEM);

    // Front-end bits that a flush overrides (the flushed stages are discarded anyway)
    localparam logic [4:0] STALL_MASK_FRONT = STALL_MASK_ID;

    typedef enum logic [1:0] {
        CTRL_RUN        = 2'd0,
        CTRL_HOLD       = 2'd1,
        CTRL_FLUSH_PEND = 2'd2
    } ctrl_state_t;

    // Deepest requesting stage wins
    function automatic logic [4:0] stall_merge(input logic if_req, input logic id_req, input logic mem_req);
        logic [4:0] m;
        if (mem_req)     m = STALL_MASK_MEM;
        else if (id_req) m = STALL_MASK_ID;
        else if (if_req) m = STALL_MASK_IF;
        else             m = STALL_MASK_NONE;
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stall/flush bus between pipeline stages and pipe_ctrl (perf ports under PIPE_CTRL_PERF_EN)
interface pipe_ctrl_if;
    logic        if_stall_req;
    logic        id_stall_req;
    logic        mem_stall_req;
    logic        jump_flag_i;
    logic [31:0] jump_target_i;
    logic [4:0]  stall_signal;
    logic        jump_flag;
    logic        redirect_o;
    logic [31:0] pc_target_o;
    logic        if_abort_o;
    logic        wdog_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_mem_stall_o;
    logic [31:0] perf_id_stall_o;
    logic [31:0] perf_if_stall_o;
    logic [31:0] perf_flush_o;
`endif

    modport master (
        output if_stall_req, id_stall_req, mem_stall_req, jump_flag_i, jump_target_i,
`ifdef PIPE_CTRL_PERF_EN
        input  perf_mem_stall_o, perf_id_stall_o, perf_if_stall_o, perf_flush_o,
`endif
        input  stall_signal, jump_flag, redirect_o, pc_target_o, if_abort_o, wdog_o
    );

    modport slave (
        input  if_stall_req, id_stall_req, mem_stall_req, jump_flag_i, jump_target_i,
`ifdef PIPE_CTRL_PERF_EN
        output perf_mem_stall_o, perf_id_stall_o, perf_if_stall_o, perf_flush_o,
`endif
        output stall_signal, jump_flag, redirect_o, pc_target_o, if_abort_o, wdog_o
    );
endinterface

// File: rtl/pipe_ctrl_stall_wdog.sv
// rtl/pipe_ctrl_stall_wdog.sv - saturating consecutive-stall counter with sticky hang flag
module pipe_ctrl_stall_wdog #(
    parameter int WDOG_CYCLES = 1023,
    parameter int WDOG_W      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_stall,
    output logic o_wdog
);

    localparam logic [WDOG_W-1:0] LP_LIMIT = WDOG_W'(WDOG_CYCLES);

    logic [WDOG_W-1:0] r_cnt;
    logic [WDOG_W-1:0] w_cnt_next;
    logic              r_flag;

    // Count consecutive stalled cycles, holding at the limit instead of wrapping
    always_comb begin
        w_cnt_next = r_cnt;
        if (!i_stall)              w_cnt_next = '0;
        else if (r_cnt != LP_LIMIT) w_cnt_next = r_cnt + 1'b1;
    end

    // Counter register and sticky flag; only rst clears the flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_flag <= r_flag | (w_cnt_next == LP_LIMIT);
        end
    end

    assign o_wdog = r_flag;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge, jump flush sequencer and stall watchdog (optional perf counters: PIPE_CTRL_PERF_EN)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WDOG_CYCLES = 1023,
    parameter int WDOG_W      = 10
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    ctrl_state_t r_state;
    ctrl_state_t w_state_next;
    logic [31:0] r_pending;
    logic [4:0]  w_stall_raw;
    logic [4:0]  w_stall;
    logic        w_flush;
    logic        w_abort;
    logic [31:0] w_target;
    logic        w_jump_frozen;
    logic        w_wdog;

    // A jump arriving while MEM is frozen cannot flush yet and must be parked
    assign w_jump_frozen = bus.jump_flag_i && bus.mem_stall_req;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= CTRL_RUN;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CTRL_RUN: begin
                if (w_jump_frozen)          w_state_next = CTRL_FLUSH_PEND;
                else if (bus.mem_stall_req) w_state_next = CTRL_HOLD;
            end
            CTRL_HOLD: begin
                if (w_jump_frozen)           w_state_next = CTRL_FLUSH_PEND;
                else if (!bus.mem_stall_req) w_state_next = CTRL_RUN;
            end
            CTRL_FLUSH_PEND: begin
                if (!bus.mem_stall_req) w_state_next = CTRL_RUN;
            end
            default: w_state_next = CTRL_RUN;
        endcase
    end

    // Park the redirect target when the jump is deferred; later re-presentations are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else if ((r_state == CTRL_RUN || r_state == CTRL_HOLD) && w_jump_frozen) begin
            r_pending <= bus.jump_target_i;
        end
    end

    // Output logic: stall merge plus same-cycle flush; everything quiet while in reset
    always_comb begin
        w_stall_raw = stall_merge(bus.if_stall_req, bus.id_stall_req, bus.mem_stall_req);
        w_flush     = 1'b0;
        w_abort     = 1'b0;
        w_target    = '0;
        if (!rst) begin
            case (r_state)
                CTRL_RUN, CTRL_HOLD: begin
                    if (bus.jump_flag_i && !bus.mem_stall_req) begin
                        w_flush  = 1'b1;
                        w_target = bus.jump_target_i;
                        w_abort  = bus.if_stall_req;
                    end
                end
                CTRL_FLUSH_PEND: begin
                    if (!bus.mem_stall_req) begin
                        w_flush  = 1'b1;
                        w_target = r_pending;
                        w_abort  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (rst)          w_stall = STALL_MASK_NONE;
        else if (w_flush) w_stall = w_stall_raw & ~STALL_MASK_FRONT;
        else              w_stall = w_stall_raw;
    end

    pipe_ctrl_stall_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES),
        .WDOG_W      (WDOG_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .i_stall (w_stall != STALL_MASK_NONE),
        .o_wdog  (w_wdog)
    );

    assign bus.stall_signal = w_stall;
    assign bus.jump_flag    = w_flush;
    assign bus.redirect_o   = w_flush;
    assign bus.pc_target_o  = w_target;
    assign bus.if_abort_o   = w_abort;
    assign bus.wdog_o       = w_wdog;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_mem;
    logic [31:0] r_perf_id;
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_flush;

    // Wrapping event counters; ID/IF count only when that request is what drives the bus
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_mem   <= '0;
            r_perf_id    <= '0;
            r_perf_if    <= '0;
            r_perf_flush <= '0;
        end else begin
            if (bus.mem_stall_req)        r_perf_mem   <= r_perf_mem + 32'd1;
            if (w_stall == STALL_MASK_ID) r_perf_id    <= r_perf_id + 32'd1;
            if (w_stall == STALL_MASK_IF) r_perf_if    <= r_perf_if + 32'd1;
            if (w_flush)                  r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign bus.perf_mem_stall_o = r_perf_mem;
    assign bus.perf_id_stall_o  = r_perf_id;
    assign bus.perf_if_stall_o  = r_perf_if;
    assign bus.perf_flush_o     = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl (perf checks under PIPE_CTRL_PERF_EN)
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .WDOG_CYCLES (8),
        .WDOG_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [4:0]  stall;
        logic        flush;
        logic [31:0] tgt;
        logic        abort;
        logic        wdog;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic i_if, input logic i_id, input logic i_mem, input logic i_j, input logic [31:0] i_t);
        bus.if_stall_req  = i_if;
        bus.id_stall_req  = i_id;
        bus.mem_stall_req = i_mem;
        bus.jump_flag_i   = i_j;
        bus.jump_target_i = i_t;
    endtask

    // One cycle: drive inputs, queue expectation, compare mid-cycle, advance past the edge
    task automatic step(input string tag,
                        input logic i_if, input logic i_id, input logic i_mem, input logic i_j, input logic [31:0] i_t,
                        input logic [4:0] e_stall, input logic e_flush, input logic [31:0] e_tgt,
                        input logic e_abort, input logic e_wdog);
        exp_t  e;
        string t;
        drive(i_if, i_id, i_mem, i_j, i_t);
        exp_q.push_back('{stall: e_stall, flush: e_flush, tgt: e_tgt, abort: e_abort, wdog: e_wdog});
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".stall"},  32'(bus.stall_signal), 32'(e.stall));
        check({t, ".jflag"},  32'(bus.jump_flag),    32'(e.flush));
        check({t, ".redir"},  32'(bus.redirect_o),   32'(e.flush));
        check({t, ".target"}, bus.pc_target_o,       e.tgt);
        check({t, ".abort"},  32'(bus.if_abort_o),   32'(e.abort));
        check({t, ".wdog"},   32'(bus.wdog_o),       32'(e.wdog));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        reset_dut();

        // Reset state
        check("reset.state", 32'(dut.r_state), 32'(CTRL_RUN));
        step("reset.idle", 0, 0, 0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 0);

        // IF stall for exactly three cycles
        for (int i = 0; i < 3; i++)
            step($sformatf("if_stall%0d", i), 1, 0, 0, 0, 32'h0, 5'b00011, 0, 32'h0, 0, 0);
        step("if_release", 0, 0, 0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 0);

        // ID beats IF
        step("id_if", 1, 1, 0, 0, 32'h0, 5'b00111, 0, 32'h0, 0, 0);
        step("id_only", 0, 1, 0, 0, 32'h0, 5'b00111, 0, 32'h0, 0, 0);

        // Jump in RUN with IF busy: same-cycle flush, abort, front stall suppressed
        step("jump_run", 1, 1, 0, 1, 32'h104, 5'b00000, 1, 32'h104, 1, 0);
        step("jump_after", 0, 0, 0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 0);
        step("jump_noabort", 0, 0, 0, 1, 32'h108, 5'b00000, 1, 32'h108, 0, 0);

        // Jump deferred across a MEM stall, released exactly once
        step("mem_hold", 0, 0, 1, 0, 32'h0, 5'b11111, 0, 32'h0, 0, 0);
        check("mem_hold.state", 32'(dut.r_state), 32'(CTRL_HOLD));
        for (int i = 0; i < 4; i++)
            step($sformatf("mem_jump%0d", i), 1, 1, 1, 1, 32'h200, 5'b11111, 0, 32'h0, 0, 0);
        check("pend.state", 32'(dut.r_state), 32'(CTRL_FLUSH_PEND));
        step("pend_release", 0, 0, 0, 1, 32'h999, 5'b00000, 1, 32'h200, 1, 0);
        step("pend_after", 0, 0, 0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 0);
        check("pend_after.state", 32'(dut.r_state), 32'(CTRL_RUN));

        // Watchdog: sets after 8 consecutive stall cycles, sticky afterwards
        reset_dut();
        for (int i = 1; i <= 9; i++)
            step($sformatf("wdog%0d", i), 0, 0, 1, 0, 32'h0, 5'b11111, 0, 32'h0, 0, (i >= 9) ? 1'b1 : 1'b0);
        step("wdog_drop0", 0, 0, 0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 1);
        step("wdog_drop1", 0, 0, 0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 1);

        // Reset while a redirect is parked: it must never appear
        reset_dut();
        step("rstpend_jump", 0, 0, 1, 1, 32'h4444, 5'b11111, 0, 32'h0, 0, 0);
        step("rstpend_hold", 0, 0, 1, 1, 32'h4444, 5'b11111, 0, 32'h0, 0, 0);
        rst = 1'b1;
        step("rstpend_inrst", 0, 0, 0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            step($sformatf("rstpend_idle%0d", i), 0, 0, 0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 0);
        check("rstpend.state", 32'(dut.r_state), 32'(CTRL_RUN));

`ifdef PIPE_CTRL_PERF_EN
        reset_dut();
        for (int i = 0; i < 5; i++)
            step($sformatf("perf_mem%0d", i), 0, 0, 1, 0, 32'h0, 5'b11111, 0, 32'h0, 0, 0);
        step("perf_rel", 0, 0, 0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 0);
        step("perf_j0", 0, 0, 0, 1, 32'h40, 5'b00000, 1, 32'h40, 0, 0);
        step("perf_idle0", 0, 0, 0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 0);
        step("perf_j1", 0, 0, 0, 1, 32'h80, 5'b00000, 1, 32'h80, 0, 0);
        step("perf_idle1", 0, 0, 0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 0);
        check("perf_mem", bus.perf_mem_stall_o, 32'd5);
        check("perf_flush", bus.perf_flush_o, 32'd2);
        check("perf_id", bus.perf_id_stall_o, 32'd0);
        check("perf_if", bus.perf_if_stall_o, 32'd0);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
